// File: rtl/mmu_mem_arbiter_pkg.sv
// Shared encodings and the request-register layout for the MMU memory arbiter.
// Source IDs double as the tag stored per outstanding read.
package mmu_mem_arbiter_pkg;

    localparam logic SRC_WALK = 1'b0;
    localparam logic SRC_ACC  = 1'b1;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        src;
        logic        rw;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } req_t;

endpackage

// File: rtl/mmu_mem_arbiter_tagfifo.sv
// 1-bit-wide tag FIFO recording which requester owns each outstanding read.
// A pop is honoured only when non-empty; a push is honoured when not full or when popping.
module mmu_mem_arbiter_tagfifo #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iPUSH,
    input  logic                 iPUSH_DATA,
    input  logic                 iPOP,
    output logic                 oPOP_DATA,
    output logic [P_DEPTH_N:0]   oCOUNT,
    output logic                 oFULL,
    output logic                 oEMPTY
);

    localparam logic [P_DEPTH_N:0] DEPTH_C = (P_DEPTH_N + 1)'(P_DEPTH);

    logic [P_DEPTH-1:0]   mem_q, mem_d;
    logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_N:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    always_comb begin
        pop_ok   = iPOP && (count_q != '0);
        push_ok  = iPUSH && ((count_q != DEPTH_C) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = iPUSH_DATA;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign oPOP_DATA = mem_q[rd_ptr_q];
    assign oCOUNT    = count_q;
    assign oFULL     = (count_q == DEPTH_C);
    assign oEMPTY    = (count_q == '0);

endmodule

// File: rtl/mmu_mem_arbiter.sv
// Merges MMU page-walk reads and translated accesses onto one 64-bit memory bus,
// steering in-order read responses back to their owner via a tag FIFO.
module mmu_mem_arbiter
    import mmu_mem_arbiter_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2,
    parameter int P_STARVE  = 4
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iWALK_REQ,
    output logic        oWALK_LOCK,
    input  logic [31:0] iWALK_ADDR,
    output logic        oWALK_VALID,
    input  logic        iWALK_LOCK,
    output logic [63:0] oWALK_DATA,
    input  logic        iACC_REQ,
    output logic        oACC_LOCK,
    input  logic        iACC_RW,
    input  logic [31:0] iACC_ADDR,
    input  logic [63:0] iACC_DATA,
    input  logic [7:0]  iACC_MASK,
    output logic        oACC_VALID,
    input  logic        iACC_LOCK,
    output logic [63:0] oACC_DATA,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [63:0] oMEM_DATA,
    output logic [7:0]  oMEM_MASK,
    input  logic        iMEM_VALID,
    output logic        oMEM_LOCK,
    input  logic [63:0] iMEM_DATA
);

    localparam int                   STARVE_W   = $clog2(P_STARVE + 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(P_STARVE);
    localparam logic [P_DEPTH_N+1:0] DEPTH_W    = (P_DEPTH_N + 2)'(P_DEPTH);

    req_t                req_q, req_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic               issue, slot_free, reg_read, read_hazard;
    logic               walk_ok, acc_ok, acc_force, walk_grant, acc_grant;
    logic               push, pop, resp_walk, resp_acc, mem_lock;
    logic               fifo_head, fifo_full, fifo_empty;
    logic [P_DEPTH_N:0] fifo_count;

    always_comb begin
        issue     = req_q.valid && !iMEM_LOCK;
        slot_free = !req_q.valid || issue;
        reg_read  = req_q.valid && (req_q.rw == READ);
        // A read already sitting in the register will claim a tag slot, so count it.
        read_hazard = fifo_full ||
            (({1'b0, fifo_count} + {{(P_DEPTH_N + 1){1'b0}}, reg_read}) >= DEPTH_W);
        walk_ok    = iWALK_REQ && slot_free && !read_hazard;
        acc_ok     = iACC_REQ && slot_free && !((iACC_RW == READ) && read_hazard);
        acc_force  = iACC_REQ && (starve_q == STARVE_MAX);
        acc_grant  = acc_ok && (acc_force || !walk_ok);
        walk_grant = walk_ok && !acc_grant;
        push       = issue && (req_q.rw == READ);

        req_d = req_q;
        if (issue) begin
            req_d.valid = 1'b0;
        end
        if (walk_grant) begin
            req_d.valid = 1'b1;
            req_d.src   = SRC_WALK;
            req_d.rw    = READ;
            req_d.addr  = iWALK_ADDR;
            req_d.data  = '0;
            req_d.mask  = 8'hFF;
        end else if (acc_grant) begin
            req_d.valid = 1'b1;
            req_d.src   = SRC_ACC;
            req_d.rw    = iACC_RW;
            req_d.addr  = iACC_ADDR;
            req_d.data  = iACC_DATA;
            req_d.mask  = iACC_MASK;
        end

        starve_d = starve_q;
        if (!iACC_REQ || acc_grant) begin
            starve_d = '0;
        end else if (walk_grant && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        resp_walk = !fifo_empty && (fifo_head == SRC_WALK);
        resp_acc  = !fifo_empty && (fifo_head == SRC_ACC);
        mem_lock  = 1'b0;
        if (resp_walk) begin
            mem_lock = iWALK_LOCK;
        end else if (resp_acc) begin
            mem_lock = iACC_LOCK;
        end
        pop = iMEM_VALID && !mem_lock && !fifo_empty;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            req_q    <= '0;
            starve_q <= '0;
        end else begin
            req_q    <= req_d;
            starve_q <= starve_d;
        end
    end

    mmu_mem_arbiter_tagfifo #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_tagfifo (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iPUSH      (push),
        .iPUSH_DATA (req_q.src),
        .iPOP       (pop),
        .oPOP_DATA  (fifo_head),
        .oCOUNT     (fifo_count),
        .oFULL      (fifo_full),
        .oEMPTY     (fifo_empty)
    );

`ifndef SYNTHESIS
    always @(posedge iCLOCK) begin
        if (inRESET && iMEM_VALID && fifo_empty) begin
            $display("mmu_mem_arbiter: orphan read response dropped at %0t", $time);
        end
    end
`endif

    assign oWALK_LOCK  = iWALK_REQ && !walk_grant;
    assign oACC_LOCK   = iACC_REQ && !acc_grant;
    assign oWALK_VALID = iMEM_VALID && resp_walk;
    assign oACC_VALID  = iMEM_VALID && resp_acc;
    assign oWALK_DATA  = iMEM_DATA;
    assign oACC_DATA   = iMEM_DATA;
    assign oMEM_LOCK   = mem_lock;
    assign oMEM_REQ    = req_q.valid;
    assign oMEM_RW     = req_q.rw;
    assign oMEM_ADDR   = req_q.addr;
    assign oMEM_DATA   = req_q.data;
    assign oMEM_MASK   = req_q.mask;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation and mid-operation reset.
module tb_mmu_mem_arbiter;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iWALK_REQ, oWALK_LOCK, oWALK_VALID, iWALK_LOCK;
    logic [31:0] iWALK_ADDR;
    logic [63:0] oWALK_DATA;
    logic        iACC_REQ, oACC_LOCK, iACC_RW, oACC_VALID, iACC_LOCK;
    logic [31:0] iACC_ADDR;
    logic [63:0] iACC_DATA, oACC_DATA;
    logic [7:0]  iACC_MASK;
    logic        oMEM_REQ, iMEM_LOCK, oMEM_RW, iMEM_VALID, oMEM_LOCK;
    logic [31:0] oMEM_ADDR;
    logic [63:0] oMEM_DATA, iMEM_DATA;
    logic [7:0]  oMEM_MASK;

    always #5 iCLOCK = ~iCLOCK;

    mmu_mem_arbiter dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iWALK_REQ(iWALK_REQ), .oWALK_LOCK(oWALK_LOCK), .iWALK_ADDR(iWALK_ADDR),
        .oWALK_VALID(oWALK_VALID), .iWALK_LOCK(iWALK_LOCK), .oWALK_DATA(oWALK_DATA),
        .iACC_REQ(iACC_REQ), .oACC_LOCK(oACC_LOCK), .iACC_RW(iACC_RW),
        .iACC_ADDR(iACC_ADDR), .iACC_DATA(iACC_DATA), .iACC_MASK(iACC_MASK),
        .oACC_VALID(oACC_VALID), .iACC_LOCK(iACC_LOCK), .oACC_DATA(oACC_DATA),
        .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_RW(oMEM_RW),
        .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .oMEM_MASK(oMEM_MASK),
        .iMEM_VALID(iMEM_VALID), .oMEM_LOCK(oMEM_LOCK), .iMEM_DATA(iMEM_DATA)
    );

    typedef struct {
        logic        wreq;
        logic [31:0] waddr;
        logic        areq;
        logic        arw;
        logic [31:0] aaddr;
        logic [7:0]  amask;
        logic        mlock;
        logic        mvalid;
        logic [63:0] mdata;
        logic        wlock;
        logic        alock;
        logic        e_wlk;
        logic        e_alk;
        logic        e_wv;
        logic        e_av;
        logic        e_ml;
        logic        e_req;
        logic        e_rw;
        logic [31:0] e_addr;
        logic [7:0]  e_mask;
        logic        chk_pay;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(
        input logic wreq, input logic [31:0] waddr, input logic areq, input logic arw,
        input logic [31:0] aaddr, input logic [7:0] amask, input logic mlock,
        input logic mvalid, input logic [63:0] mdata, input logic wlock, input logic alock,
        input logic e_wlk, input logic e_alk, input logic e_wv, input logic e_av,
        input logic e_ml, input logic e_req, input logic e_rw, input logic [31:0] e_addr,
        input logic [7:0] e_mask, input logic chk_pay);
        vec_t v;
        v.wreq = wreq; v.waddr = waddr; v.areq = areq; v.arw = arw; v.aaddr = aaddr;
        v.amask = amask; v.mlock = mlock; v.mvalid = mvalid; v.mdata = mdata;
        v.wlock = wlock; v.alock = alock; v.e_wlk = e_wlk; v.e_alk = e_alk;
        v.e_wv = e_wv; v.e_av = e_av; v.e_ml = e_ml; v.e_req = e_req; v.e_rw = e_rw;
        v.e_addr = e_addr; v.e_mask = e_mask; v.chk_pay = chk_pay;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        iWALK_REQ = 0; iWALK_ADDR = '0; iWALK_LOCK = 0;
        iACC_REQ = 0; iACC_RW = 0; iACC_ADDR = '0; iACC_DATA = '0; iACC_MASK = '0; iACC_LOCK = 0;
        iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_DATA = '0;
    endtask

    initial begin
        string   nm;
        logic [9:0] starve_exp;
        int      pend;
        int      got;
        logic    issued_read, popped;

        idle_inputs();
        inRESET = 0;
        #12;
        check("reset_mem_req", oMEM_REQ, 0);
        check("reset_mem_addr", oMEM_ADDR, 0);
        check("reset_mem_mask", oMEM_MASK, 0);
        @(negedge iCLOCK);
        inRESET = 1;
        @(posedge iCLOCK);
        #1;

        //  wreq waddr    areq arw aaddr    amask ml mv mdata                   wl al | wlk alk wv av ml req rw addr     mask  chk
        add(1, 32'h1000, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h1000, 8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 0,  0, 0, 1, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    1, 1, 32'h2000, 8'hF0, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 1, 32'h2000, 8'hF0, 1);
        add(0, 32'h0,    1, 0, 32'h2008, 8'hFF, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h2008, 8'hFF, 1);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'h1111_2222_3333_4444, 0, 0,  0, 0, 0, 1, 0, 0, 0, 32'h0,    8'h00, 0);
        add(1, 32'h3000, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h3000, 8'h00, 0);
        add(1, 32'h3008, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h3008, 8'h00, 0);
        add(1, 32'h3010, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h3010, 8'h00, 0);
        add(1, 32'h3018, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h3018, 8'h00, 0);
        add(1, 32'h3020, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  1, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(1, 32'h3020, 1, 1, 32'h4000, 8'h0F, 0, 0, 64'h0,                   0, 0,  1, 0, 0, 0, 0, 1, 1, 32'h4000, 8'h0F, 1);
        add(1, 32'h3020, 0, 0, 32'h0,    8'h00, 0, 1, 64'hA5A5_A5A5_5A5A_5A5A, 0, 0,  1, 0, 1, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(1, 32'h3020, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h3020, 8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        for (int k = 0; k < 4; k++)
            add(0, 32'h0, 0, 0, 32'h0, 8'h00, 0, 1, 64'h5000_0000_0000_0000 + 64'(k), 0, 0,
                0, 0, 1, 0, 0, 0, 0, 32'h0, 8'h00, 0);
        add(0, 32'h0,    1, 0, 32'h5000, 8'hFF, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h5000, 8'hFF, 1);
        add(1, 32'h6000, 0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 1, 0, 32'h6000, 8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 0, 64'h0,                   0, 0,  0, 0, 0, 0, 0, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 1,  0, 0, 0, 1, 1, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 1,  0, 0, 0, 1, 1, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0,  0, 0, 0, 1, 0, 0, 0, 32'h0,    8'h00, 0);
        add(0, 32'h0,    0, 0, 32'h0,    8'h00, 0, 1, 64'hFEDC_BA98_7654_3210, 0, 1,  0, 0, 1, 0, 0, 0, 0, 32'h0,    8'h00, 0);

        foreach (vecs[i]) begin
            iWALK_REQ = vecs[i].wreq; iWALK_ADDR = vecs[i].waddr;
            iACC_REQ = vecs[i].areq; iACC_RW = vecs[i].arw; iACC_ADDR = vecs[i].aaddr;
            iACC_MASK = vecs[i].amask; iACC_DATA = {32'hCAFE_F00D, vecs[i].aaddr};
            iMEM_LOCK = vecs[i].mlock; iMEM_VALID = vecs[i].mvalid; iMEM_DATA = vecs[i].mdata;
            iWALK_LOCK = vecs[i].wlock; iACC_LOCK = vecs[i].alock;
            #1;
            nm = $sformatf("row%0d", i);
            check({nm, "_walk_lock"}, oWALK_LOCK, vecs[i].e_wlk);
            check({nm, "_acc_lock"}, oACC_LOCK, vecs[i].e_alk);
            check({nm, "_walk_valid"}, oWALK_VALID, vecs[i].e_wv);
            check({nm, "_acc_valid"}, oACC_VALID, vecs[i].e_av);
            check({nm, "_mem_lock"}, oMEM_LOCK, vecs[i].e_ml);
            check({nm, "_walk_data"}, oWALK_DATA, vecs[i].mdata);
            check({nm, "_acc_data"}, oACC_DATA, vecs[i].mdata);
            @(posedge iCLOCK);
            #1;
            check({nm, "_mem_req"}, oMEM_REQ, vecs[i].e_req);
            if (vecs[i].e_req) begin
                check({nm, "_mem_rw"}, oMEM_RW, vecs[i].e_rw);
                check({nm, "_mem_addr"}, oMEM_ADDR, vecs[i].e_addr);
            end
            if (vecs[i].chk_pay) begin
                check({nm, "_mem_mask"}, oMEM_MASK, vecs[i].e_mask);
                check({nm, "_mem_data"}, oMEM_DATA, {32'hCAFE_F00D, vecs[i].e_addr});
            end
        end

        // Both requesters held; walk reads answered one cycle after they issue.
        idle_inputs();
        starve_exp = 10'b1000010000;   // bit k set = access expected at step k
        pend = 0;
        for (int k = 0; k < 10; k++) begin
            iWALK_REQ = 1; iWALK_ADDR = 32'h8000;
            iACC_REQ = 1; iACC_RW = 1; iACC_ADDR = 32'h9000; iACC_MASK = 8'h3C;
            iMEM_VALID = (pend > 0); iMEM_DATA = 64'h77;
            #1;
            got = !oWALK_LOCK ? 0 : (!oACC_LOCK ? 1 : 2);
            check($sformatf("starve_grant%0d", k), got, starve_exp[k] ? 1 : 0);
            issued_read = oMEM_REQ && !oMEM_RW;
            popped = iMEM_VALID && !oMEM_LOCK;
            @(posedge iCLOCK);
            #1;
            check($sformatf("starve_addr%0d", k), oMEM_ADDR, starve_exp[k] ? 32'h9000 : 32'h8000);
            pend = pend + int'(issued_read) - int'(popped);
        end
        iWALK_REQ = 0; iACC_REQ = 0;
        for (int j = 0; j < 4; j++) begin
            iMEM_VALID = (pend > 0);
            #1;
            if (pend > 0) check($sformatf("drain_walk_valid%0d", j), oWALK_VALID, 1);
            issued_read = oMEM_REQ && !oMEM_RW;
            popped = iMEM_VALID && !oMEM_LOCK;
            @(posedge iCLOCK);
            #1;
            pend = pend + int'(issued_read) - int'(popped);
        end
        check("drain_pending", pend, 0);

        // Reset with one read queued in the tag FIFO and one in the register.
        idle_inputs();
        iWALK_REQ = 1; iWALK_ADDR = 32'h7000;
        @(posedge iCLOCK); #1;
        iWALK_ADDR = 32'h7008;
        @(posedge iCLOCK); #1;
        check("pre_reset_mem_req", oMEM_REQ, 1);
        check("pre_reset_mem_addr", oMEM_ADDR, 32'h7008);
        iWALK_REQ = 0;
        inRESET = 0;
        #1;
        check("rst_mem_req", oMEM_REQ, 0);
        check("rst_mem_rw", oMEM_RW, 0);
        check("rst_mem_addr", oMEM_ADDR, 0);
        check("rst_mem_data", oMEM_DATA, 0);
        check("rst_mem_mask", oMEM_MASK, 0);
        @(negedge iCLOCK);
        inRESET = 1;
        @(posedge iCLOCK); #1;
        iMEM_VALID = 1; iMEM_DATA = 64'hBAD0_BAD0_BAD0_BAD0; iWALK_LOCK = 1; iACC_LOCK = 1;
        #1;
        check("orphan_walk_valid", oWALK_VALID, 0);
        check("orphan_acc_valid", oACC_VALID, 0);
        check("orphan_mem_lock", oMEM_LOCK, 0);
        @(posedge iCLOCK); #1;
        idle_inputs();
        iWALK_REQ = 1; iWALK_ADDR = 32'h7010;
        #1;
        check("post_rst_walk_lock", oWALK_LOCK, 0);
        @(posedge iCLOCK); #1;
        check("post_rst_mem_req", oMEM_REQ, 1);
        check("post_rst_mem_addr", oMEM_ADDR, 32'h7010);
        iWALK_REQ = 0;
        @(posedge iCLOCK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
